// File: rtl/trig_pkg.sv
// Shared constants and types for the trig lookup path.
//   ANGLE_FULL  one full turn in degrees
//   SIN_OFFSET  sin(a) = cos(a + SIN_OFFSET)
//   FP_ONE      Q16.16 representation of 1.0
package trig_pkg;

  localparam int unsigned ANGLE_FULL = 360;
  localparam int unsigned SIN_OFFSET = 270;
  localparam int unsigned FP_ONE     = 65536;

  typedef enum logic {
    TRIG_COS = 1'b0,
    TRIG_SIN = 1'b1
  } trig_func_e;

  typedef logic [8:0]         angle_t;
  typedef logic signed [31:0] trig_val_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, reusable for any shared resource.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   req           per-requester request
//   advance       a grant was consumed this cycle; rotate priority past the winner
//   grant         one-hot grant (combinational), zero when no request
//   grant_idx     index of the granted requester
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int unsigned   j;

  // Scan from ptr upwards with wrap; first requester seen wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = {{(32-IW){1'b0}}, ptr} + k;
      if (j >= N) j = j - N;
      if (!found && req[j[IW-1:0]]) begin
        found                = 1'b1;
        grant[j[IW-1:0]]     = 1'b1;
        grant_idx            = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trig_lookup_arbiter.sv
// Shares one external cosine ROM between N_REQ requesters.
// Requests are granted round-robin, the angle is folded into 0..359 (sin is
// looked up as cos(a+270)), and the result returns two cycles after the grant
// tagged with the requester id.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/angle/func  per-requester request (func 0=cos, 1=sin)
//   req_ready             one-hot combinational grant
//   rom_angle/rom_value   registered ROM address / ROM data
//   rsp_valid/id/value    one-cycle result strobe, owner id, Q16.16 result
// Optional (macro TRIG_ARB_STATS_EN):
//   grant_count           16-bit saturating grant counter per requester
//   stats_clr             synchronous clear of all counters (wins over count)
module trig_lookup_arbiter
  import trig_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ANGLE_W = 9,
  parameter int unsigned VAL_W   = 32,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ANGLE_W-1:0] req_angle,
  input  logic [N_REQ-1:0]         req_func,
  output logic [N_REQ-1:0]         req_ready,
  output logic [ANGLE_W-1:0]       rom_angle,
  input  logic [VAL_W-1:0]         rom_value,
`ifdef TRIG_ARB_STATS_EN
  input  logic                     stats_clr,
  output logic [N_REQ*16-1:0]      grant_count,
`endif
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [VAL_W-1:0]         rsp_value
);

  localparam int unsigned SW = ANGLE_W + 1;

  logic               advance;
  logic [ID_W-1:0]    grant_idx;
  logic [ANGLE_W-1:0] win_angle;
  trig_func_e         win_func;
  logic [SW-1:0]      a_ext, a1, s, r;
  logic [ID_W-1:0]    s1_id;
  logic               s1_valid;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .advance   (advance),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign advance = |(req_valid & req_ready);

  // Input range is 0..511, so a single conditional subtract folds into 0..359.
  always_comb begin
    win_angle = req_angle[grant_idx*ANGLE_W +: ANGLE_W];
    win_func  = trig_func_e'(req_func[grant_idx]);
    a_ext     = {1'b0, win_angle};
    a1        = (a_ext >= SW'(ANGLE_FULL)) ? a_ext - SW'(ANGLE_FULL) : a_ext;
    s         = a1 + ((win_func == TRIG_SIN) ? SW'(SIN_OFFSET) : SW'(0));
    r         = (s >= SW'(ANGLE_FULL)) ? s - SW'(ANGLE_FULL) : s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_angle <= '0;
      s1_id     <= '0;
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_value <= '0;
    end else begin
      s1_valid  <= advance;
      rsp_valid <= s1_valid;
      if (advance) begin
        rom_angle <= r[ANGLE_W-1:0];
        s1_id     <= grant_idx;
      end
      if (s1_valid) begin
        rsp_value <= rom_value;
        rsp_id    <= s1_id;
      end
    end
  end

`ifdef TRIG_ARB_STATS_EN
  logic [N_REQ*16-1:0] cnt;

  assign grant_count = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (stats_clr) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (cnt[i*16 +: 16] != 16'hFFFF)) begin
          cnt[i*16 +: 16] <= cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
module tb_trig_lookup_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int VW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_angle;
  logic [N-1:0]    req_func;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_angle;
  logic [VW-1:0]   rom_value;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [VW-1:0]   rsp_value;
`ifdef TRIG_ARB_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] grant_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  trig_lookup_arbiter #(
    .N_REQ   (N),
    .ANGLE_W (AW),
    .VAL_W   (VW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_angle   (req_angle),
    .req_func    (req_func),
    .req_ready   (req_ready),
    .rom_angle   (rom_angle),
    .rom_value   (rom_value),
`ifdef TRIG_ARB_STATS_EN
    .stats_clr   (stats_clr),
    .grant_count (grant_count),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_value   (rsp_value)
  );

  always #5 clk = ~clk;

  // External cosine ROM: round(cos(deg) * 65536).
  function automatic int cos_q16(input int deg);
    real v;
    v = $cos(real'(deg) * 3.14159265358979323846 / 180.0) * 65536.0;
    return int'($floor(v + 0.5));
  endfunction

  assign rom_value = cos_q16(int'(rom_angle));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: priority pointer, in-flight lookup and last response.
  int m_ptr, m_rom, m_s1_v, m_s1_id, m_rsp_v, m_rsp_id, m_rsp_val;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_rom = 0; m_s1_v = 0; m_s1_id = 0;
      m_rsp_v = 0; m_rsp_id = 0; m_rsp_val = 0;
    end else begin
      int w, a, f, exp_ready;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      exp_ready = (w < 0) ? 0 : (1 << w);
      chk("m_ready", int'(req_ready), exp_ready);
      chk("m_rom_angle", int'(rom_angle), m_rom);
      chk("m_rsp_valid", int'(rsp_valid), m_rsp_v);
      chk("m_rsp_id", int'(rsp_id), m_rsp_id);
      chk("m_rsp_value", $signed(rsp_value), m_rsp_val);
      // Advance to the state after the coming rising edge.
      m_rsp_v = m_s1_v;
      if (m_s1_v != 0) begin
        m_rsp_id  = m_s1_id;
        m_rsp_val = cos_q16(m_rom);
      end
      if (w >= 0) begin
        a       = int'(req_angle[w*AW +: AW]);
        f       = int'(req_func[w]);
        m_rom   = (a % 360 + (f != 0 ? 270 : 0)) % 360;
        m_s1_id = w;
        m_s1_v  = 1;
        m_ptr   = (w + 1) % N;
      end else begin
        m_s1_v = 0;
      end
    end
  end

  task automatic drive_one(input int id, input int f, input int ang);
    logic [AW-1:0] av;
    av = AW'(ang);
    req_valid              = '0;
    req_valid[id]          = 1'b1;
    req_func[id]           = f[0];
    req_angle[id*AW +: AW] = av;
  endtask

  task automatic lookup(input int id, input int f, input int ang,
                        input int exp_rom, input int exp_val);
    @(posedge clk); #1;
    drive_one(id, f, ang);
    @(negedge clk);
    chk("t_ready", int'(req_ready), 1 << id);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t_rom_angle", int'(rom_angle), exp_rom);
    @(negedge clk);
    chk("t_rsp_valid", int'(rsp_valid), 1);
    chk("t_rsp_id", int'(rsp_id), id);
    chk("t_rsp_value", $signed(rsp_value), exp_val);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n   = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_angle = '0;
    req_func  = '0;
`ifdef TRIG_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_angle", int'(rom_angle), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_value", $signed(rsp_value), 0);
    chk("rst_ready", int'(req_ready), 0);
    reset_n = 1'b1;

    // Single lookups, sin folding, out-of-range angles.
    lookup(0, 0, 60, 60, 32768);
    lookup(1, 1, 90, 0, 65536);
    lookup(1, 1, 0, 270, 0);
    lookup(1, 1, 30, 300, 32768);
    lookup(2, 0, 400, 40, 50203);
    lookup(3, 1, 500, 50, 42126);
    lookup(0, 0, 359, 359, 65526);

    // Round-robin with all requesters holding valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_func[i]           = i[0];
      req_angle[i*AW +: AW] = AW'(100 * i + 17);
    end
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) chk("rr_ready", int'(req_ready), 1 << (k % N));
      if (k >= 2) begin
        chk("rr_rsp_valid", int'(rsp_valid), 1);
        chk("rr_rsp_id", int'(rsp_id), (k - 2) % N);
      end
      @(posedge clk); #1;
      if (k == 7) req_valid = '0;
    end

    // Reset with two lookups in flight.
    @(posedge clk); #1;
    drive_one(2, 0, 10);
    @(posedge clk); #1;
    drive_one(3, 0, 20);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #2;
    chk("mid_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rom_angle", int'(rom_angle), 0);
    chk("mid_rsp_id", int'(rsp_id), 0);
    chk("mid_rsp_value", $signed(rsp_value), 0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    req_valid = 4'b1010;
    req_func[1] = 1'b0;
    req_angle[1*AW +: AW] = AW'(60);
    @(negedge clk);
    chk("mid_next_grant", int'(req_ready), 2);
    chk("mid_no_rsp0", int'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_no_rsp1", int'(rsp_valid), 0);
    @(negedge clk);
    chk("mid_new_rsp", int'(rsp_valid), 1);
    chk("mid_new_id", int'(rsp_id), 1);

`ifdef TRIG_ARB_STATS_EN
    do_reset();
    drive_one(2, 0, 0);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt2_sat", int'(grant_count[2*16 +: 16]), 65535);
    chk("cnt0_idle", int'(grant_count[0 +: 16]), 0);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    chk("cnt2_clr", int'(grant_count[2*16 +: 16]), 0);
    @(posedge clk); #1;
    chk("cnt2_after", int'(grant_count[2*16 +: 16]), 1);
    req_valid = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trig_lookup_arbiter.md
Name: trig_lookup_arbiter

Overview:
- Shares one combinational cosine ROM (angle 0..359 in, cos*2^16 out) between N_REQ requesters, such as the camera-rotation and ray-step units.
- Arbitrates requests round-robin and folds each angle into 0..359.
- Derives sin as cos(angle+270 mod 360).
- Pipelines the lookup in two stages and returns the result tagged with the requester id.

Parameters:
N_REQ, 4, number of requesters (2..8)
ANGLE_W, 9, request/ROM angle width
VAL_W, 32, signed result width (Q16.16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_angle  in  N_REQ*ANGLE_W  packed angles, requester i at bits [i*ANGLE_W +: ANGLE_W], range 0..511
req_func  in  N_REQ  per-requester function select, 0=cos, 1=sin
req_ready  out  N_REQ  one-hot grant, combinational
rom_angle  out  ANGLE_W  registered angle driving the ROM, always 0..359
rom_value  in  VAL_W  ROM output for rom_angle
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  $clog2(N_REQ)  id of the requester the result belongs to
rsp_value  out  VAL_W  signed result, cos/sin * 65536

Behaviour:
- Clock/reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - rom_angle=0, rsp_valid=0, rsp_id=0, rsp_value=0.
  - Internal s1_valid=0, s1_id=0.
  - RR pointer=0, so requester 0 has highest priority after reset.
- Arbitration (combinational):
  - Search starts at index ptr and wraps modulo N_REQ; the first set req_valid wins.
  - req_ready is one-hot on the winner, all-zero when no req_valid is set.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
  - A transfer occurs when req_valid[i] & req_ready[i]; at most one per cycle.
  - On a transfer, ptr <= winner+1, wrapping N_REQ-1 -> 0. With no transfer, ptr holds.
- Angle normalisation (combinational, on the winner):
  - a1 = (a>=360) ? a-360 : a
  - s = a1 + (func ? 270 : 0), computed 10 bits wide
  - r = (s>=360) ? s-360 : s, result in 0..359
- Stage 1 (clock after transfer T): rom_angle<=r, s1_id<=winner, s1_valid<=1. With no transfer, s1_valid<=0 and rom_angle holds.
- Stage 2 (T+2): rsp_value<=rom_value, rsp_id<=s1_id, rsp_valid<=s1_valid. When s1_valid=0, rsp_value and rsp_id hold.
- Latency and throughput:
  - Latency is exactly 2 cycles from transfer to rsp_valid.
  - Throughput is 1 lookup per cycle, back-to-back, with results in grant order.
- No response backpressure: consumers must capture a result in the cycle its rsp_valid is high.
- A requester may hold req_valid across cycles; each cycle it is granted counts as a separate lookup.
- Reset mid-operation: in-flight lookups are discarded, no rsp_valid is produced, and ptr returns to 0.
- All arithmetic on angles is unsigned. rom_value passes through unmodified as signed.

Optional Feature:
- Macro: TRIG_ARB_STATS_EN.
- Enabled:
  - Adds output grant_count, width N_REQ*16: one 16-bit saturating counter per requester, incremented on that requester's transfer.
  - Counters reset to 0 on reset_n low.
  - Adds input stats_clr (1 bit): synchronous clear of all counters. If stats_clr and a transfer occur in the same cycle, the clear wins and the counter becomes 0.
- Disabled: the ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package trig_pkg:
  - constants ANGLE_FULL=360, SIN_OFFSET=270, FP_ONE=65536
  - typedef trig_func_e {TRIG_COS=0, TRIG_SIN=1}
  - typedef angle_t = logic[8:0]
  - typedef trig_val_t = logic signed[31:0]
- Sub-module rr_arbiter: parameter N; inputs req, advance; outputs grant (one-hot) and grant_idx; owns ptr. Reused by other shared resources in the design.
- trig_lookup_arbiter instantiates rr_arbiter and contains the normalisation logic plus the two pipeline registers.
- The ROM stays outside the block and connects through rom_angle/rom_value.

Test Plan:
1. Single requester, req0 cos 60 -> ready0 same cycle; rom_angle=60 at T+1; rsp_valid=1, rsp_id=0, rsp_value=32768 at T+2.
2. Sin folding: req1 sin 90 -> rom_angle=0, value 65536. req1 sin 0 -> rom_angle=270, value 0. req1 sin 30 -> rom_angle=300, value 32768.
3. Out-of-range angles: cos 400 -> rom_angle=40, value 50203. sin 500 -> a1=140, rom_angle=50. cos 359 -> rom_angle=359, value 65526.
4. Round-robin: all 4 requesters hold valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows 2 cycles later; one rsp_valid every cycle.
5. Reset mid-flight: two transfers, then reset_n low for 1 cycle between them -> no rsp_valid for either; all outputs 0; the next grant goes to lowest-index valid requester starting from 0.
6. With TRIG_ARB_STATS_EN: 70000 transfers from req2 -> grant_count[2] saturates at 65535. stats_clr together with a transfer -> counter reads 0 next cycle.
